lock_access_ctrl: RTL
=====================

LOCK_ACCESS_CTRL -- requirements
Module: lock_access_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 5, keys per entry attempt.
REQ-002 SHALL have parameter UNLOCK_TICKS, default 5, ticks the unlock output is held.
REQ-003 SHALL have parameter LOCKOUT_TICKS, default 10, ticks of lockout after too many failures.
REQ-004 SHALL have parameter ENTRY_TIMEOUT, default 4, idle ticks that abort a partial attempt.
REQ-005 SHALL have parameter MAX_FAILS, default 3, failed attempts that trigger lockout.
REQ-006 SHALL have port clk_100Mhz  in  1  the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port tick  in  1  one-cycle timebase strobe (1 Hz rate).
REQ-009 SHALL have port key_pulse  in  1  one-cycle pulse per entered key (zero or one), from the level-to-pulse stage.
REQ-010 SHALL have port code_ok  in  1  one-cycle pulse from the sequence detector on a correct code.
REQ-011 SHALL have port unlock  out  1  lock-open drive.
REQ-012 SHALL have port alarm  out  1  lockout indicator.
REQ-013 SHALL have port fail_cnt  out  2  failed attempts since the last unlock or lockout.
REQ-014 SHALL have port seg7  out  8  status digit, active-low segments, bit7 = decimal point held 0.
REQ-015 SHALL have port enable  out  3  digit-select output, constant 3'b110.

Function
REQ-016 SHALL implement the states IDLE, ENTRY, UNLOCKED and LOCKOUT.
REQ-017 IDLE: on key_pulse, SHALL go to ENTRY with key_cnt=1 and the timeout counter cleared.
REQ-018 ENTRY: each key_pulse SHALL increment key_cnt and clear the timeout counter.
REQ-019 code_ok in IDLE or ENTRY SHALL go to UNLOCKED, clear fail_cnt, load the remaining count with UNLOCK_TICKS, and win over a key_pulse in the same cycle.
REQ-020 In ENTRY, a key_pulse that makes key_cnt reach CODE_LEN without code_ok SHALL increment fail_cnt and go to IDLE, or go to LOCKOUT if fail_cnt+1 = MAX_FAILS.
REQ-021 ENTRY: ENTRY_TIMEOUT ticks with no key SHALL return to IDLE with key_cnt cleared and fail_cnt unchanged; a key and a tick in the same cycle count as a key.
REQ-022 UNLOCKED: unlock=1; each tick SHALL decrement the remaining count; reaching 0 SHALL go to IDLE; key_pulse and code_ok SHALL be ignored.
REQ-023 LOCKOUT: alarm=1, remaining count loaded with LOCKOUT_TICKS; inputs ignored; reaching 0 SHALL go to IDLE with fail_cnt=0.
REQ-024 Outputs SHALL be registered and change one cycle after the causing input edge.
REQ-025 seg7 SHALL show 0 in IDLE, key_cnt in ENTRY, and the remaining ticks clamped to 9 in UNLOCKED/LOCKOUT.
REQ-026 Counters SHALL saturate and never wrap; fail_cnt SHALL not exceed MAX_FAILS.

Reset
REQ-027 reset SHALL force IDLE, unlock=0, alarm=0, fail_cnt=0, key_cnt=0, all counters 0 and seg7 = digit 0, immediately and asynchronously, including mid-UNLOCKED or mid-LOCKOUT.

Configuration
REQ-028 With LOCK_LOCKOUT_EN defined, SHALL implement LOCKOUT per REQ-020/REQ-023; without it, failures SHALL saturate fail_cnt, alarm SHALL be tied 0, and LOCKOUT SHALL be unreachable.

Structure
REQ-029 A shared package lock_pkg SHALL hold the state enumeration, the seven-segment digit constants 0-9 and the default timing constants.
REQ-030 The digit-to-segment decode SHALL be the sub-module lock_seg_decode (4-bit digit in, 8-bit seg7 out).

Verification
REQ-031 Reset, 5 keys with code_ok on the 5th -> unlock=1 for exactly 5 ticks, fail_cnt=0, seg7 counts down 5..1, then IDLE.
REQ-032 Three 5-key attempts without code_ok -> fail_cnt 1, 2, then alarm=1 for 10 ticks; keys ignored; then fail_cnt=0.
REQ-033 2 keys then 4 ticks idle -> IDLE, key_cnt=0, fail_cnt unchanged; key_pulse coincident with the 4th tick keeps ENTRY.
REQ-034 Assert reset during UNLOCKED with 3 ticks remaining -> unlock=0 and IDLE with no clock edge.
REQ-035 Build without LOCK_LOCKOUT_EN, 4 failed attempts -> fail_cnt saturates at 3, alarm stays 0, the next code_ok unlocks.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller: FSM states,
// seven-segment digit codes (active-low, gfedcba, DP bit held 0) and default timing.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } lock_state_e;

    localparam int unsigned CODE_LEN_DEF      = 5;
    localparam int unsigned UNLOCK_TICKS_DEF  = 5;
    localparam int unsigned LOCKOUT_TICKS_DEF = 10;
    localparam int unsigned ENTRY_TIMEOUT_DEF = 4;
    localparam int unsigned MAX_FAILS_DEF     = 3;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 8;

    localparam logic [SEG_W-1:0] SEG_0     = 8'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 8'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 8'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 8'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 8'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h7F;

    // Single display digit can only show 0-9; larger counts read as 9.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input int unsigned v);
        return (v > 9) ? DIGIT_W'(9) : DIGIT_W'(v);
    endfunction

endpackage

// File: rtl/lock_seg_decode.sv
// Combinational BCD digit to active-low seven-segment pattern (DP bit held 0).
module lock_seg_decode
    import lock_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg7
);

    always_comb begin
        seg7 = SEG_BLANK;
        case (digit)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lock_access_ctrl.sv
// Keypad lock access controller: counts entry keys, unlocks on code_ok, tracks failures.
// Optional feature macro LOCK_LOCKOUT_EN enables the timed LOCKOUT state after MAX_FAILS failures.
module lock_access_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN      = CODE_LEN_DEF,
    parameter int unsigned UNLOCK_TICKS  = UNLOCK_TICKS_DEF,
    parameter int unsigned LOCKOUT_TICKS = LOCKOUT_TICKS_DEF,
    parameter int unsigned ENTRY_TIMEOUT = ENTRY_TIMEOUT_DEF,
    parameter int unsigned MAX_FAILS     = MAX_FAILS_DEF
) (
    input  logic             clk_100Mhz,
    input  logic             reset,
    input  logic             tick,
    input  logic             key_pulse,
    input  logic             code_ok,
    output logic             unlock,
    output logic             alarm,
    output logic [1:0]       fail_cnt,
    output logic [SEG_W-1:0] seg7,
    output logic [2:0]       enable
);

    localparam int unsigned KEY_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned TO_W    = $clog2(ENTRY_TIMEOUT + 1);
    localparam int unsigned REM_MAX = (UNLOCK_TICKS > LOCKOUT_TICKS) ? UNLOCK_TICKS : LOCKOUT_TICKS;
    localparam int unsigned REM_W   = $clog2(REM_MAX + 1);
    localparam int unsigned FAIL_W  = 2;

    lock_state_e state, state_next;

    logic [KEY_W-1:0]   key_cnt, key_cnt_d, key_inc;
    logic [TO_W-1:0]    to_cnt, to_cnt_d, to_inc;
    logic [REM_W-1:0]   rem_cnt, rem_cnt_d, rem_dec;
    logic [FAIL_W-1:0]  fail_cnt_d, fail_inc;
    logic               key_full, to_done, rem_done, lockout_hit;
    logic               unlock_d, alarm_d;
    logic [DIGIT_W-1:0] digit_d;
    logic [SEG_W-1:0]   seg_d;

    // Saturating step values shared by next-state and output logic.
    assign key_inc  = (key_cnt == KEY_W'(CODE_LEN)) ? key_cnt : key_cnt + 1'b1;
    assign to_inc   = (to_cnt == TO_W'(ENTRY_TIMEOUT)) ? to_cnt : to_cnt + 1'b1;
    assign rem_dec  = (rem_cnt == '0) ? rem_cnt : rem_cnt - 1'b1;
    assign fail_inc = (fail_cnt >= FAIL_W'(MAX_FAILS)) ? FAIL_W'(MAX_FAILS) : fail_cnt + 1'b1;
    assign key_full = (key_inc == KEY_W'(CODE_LEN));
    assign to_done  = (to_inc == TO_W'(ENTRY_TIMEOUT));
    assign rem_done = (rem_dec == '0);

`ifdef LOCK_LOCKOUT_EN
    assign lockout_hit = (fail_inc == FAIL_W'(MAX_FAILS));
`else
    assign lockout_hit = 1'b0;
`endif

    assign enable = 3'b110;

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // code_ok takes priority over a coincident key; a key beats a coincident tick.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (code_ok) begin
                    state_next = ST_UNLOCKED;
                end else if (key_pulse) begin
                    if (key_full) begin
                        state_next = lockout_hit ? ST_LOCKOUT : ST_IDLE;
                    end else begin
                        state_next = ST_ENTRY;
                    end
                end else if (state == ST_ENTRY && tick && to_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_UNLOCKED, ST_LOCKOUT: begin
                if (tick && rem_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values for counters and the registered outputs.
    always_comb begin
        key_cnt_d  = key_cnt;
        to_cnt_d   = to_cnt;
        rem_cnt_d  = rem_cnt;
        fail_cnt_d = fail_cnt;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (code_ok) begin
                    key_cnt_d  = '0;
                    to_cnt_d   = '0;
                    rem_cnt_d  = REM_W'(UNLOCK_TICKS);
                    fail_cnt_d = '0;
                end else if (key_pulse) begin
                    to_cnt_d = '0;
                    if (key_full) begin
                        key_cnt_d  = '0;
                        fail_cnt_d = fail_inc;
                        if (lockout_hit) begin
                            rem_cnt_d = REM_W'(LOCKOUT_TICKS);
                        end
                    end else begin
                        key_cnt_d = key_inc;
                    end
                end else if (state == ST_ENTRY && tick) begin
                    if (to_done) begin
                        to_cnt_d  = '0;
                        key_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_inc;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (tick) begin
                    rem_cnt_d = rem_dec;
                end
            end
            ST_LOCKOUT: begin
                if (tick) begin
                    rem_cnt_d = rem_dec;
                    if (rem_done) begin
                        fail_cnt_d = '0;
                    end
                end
            end
            default: ;
        endcase

        unlock_d = (state_next == ST_UNLOCKED);
`ifdef LOCK_LOCKOUT_EN
        alarm_d  = (state_next == ST_LOCKOUT);
`else
        alarm_d  = 1'b0;
`endif
        case (state_next)
            ST_ENTRY:                digit_d = clamp_digit(32'(key_cnt_d));
            ST_UNLOCKED, ST_LOCKOUT: digit_d = clamp_digit(32'(rem_cnt_d));
            default:                 digit_d = '0;
        endcase
    end

    lock_seg_decode u_seg_decode (
        .digit (digit_d),
        .seg7  (seg_d)
    );

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            key_cnt  <= '0;
            to_cnt   <= '0;
            rem_cnt  <= '0;
            fail_cnt <= '0;
            unlock   <= 1'b0;
            alarm    <= 1'b0;
            seg7     <= SEG_0;
        end else begin
            key_cnt  <= key_cnt_d;
            to_cnt   <= to_cnt_d;
            rem_cnt  <= rem_cnt_d;
            fail_cnt <= fail_cnt_d;
            unlock   <= unlock_d;
            alarm    <= alarm_d;
            seg7     <= seg_d;
        end
    end

endmodule
